// File: rtl/mem_port_arbiter.sv
// Shares one single-port 16-bit memory between instruction fetch (I) and data
// load/store (D), holding the port for LATENCY cycles per access with round-robin ties.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int LATENCY    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_done,
    output logic [15:0]           i_rdata,
    input  logic                  d_req,
    input  logic                  d_wr,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [15:0]           d_wdata,
    output logic                  d_done,
    output logic [15:0]           d_rdata,
    output logic                  mem_enable,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [15:0]           mem_data_in,
    input  logic [15:0]           mem_data_out,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  last_d_q, last_d_d;   // 1: last grant went to D
    logic                  owner_d_q, owner_d_d; // 1: current access belongs to D
    logic                  wr_q, wr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [15:0]           wdata_q, wdata_d;
    logic [15:0]           i_rdata_q, i_rdata_d;
    logic [15:0]           d_rdata_q, d_rdata_d;
    logic                  grant_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            last_d_q  <= 1'b0;
            owner_d_q <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= 16'h0000;
            i_rdata_q <= 16'h0000;
            d_rdata_q <= 16'h0000;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_d_q  <= last_d_d;
            owner_d_q <= owner_d_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d_d    = last_d_q;
        owner_d_d   = owner_d_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        grant_d     = 1'b0;
        i_done      = 1'b0;
        d_done      = 1'b0;
        mem_enable  = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = '0;
        mem_data_in = 16'h0000;
        busy        = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    // On a tie, the requester that did not win last time gets the port.
                    grant_d   = d_req && (!i_req || !last_d_q);
                    owner_d_d = grant_d;
                    wr_d      = grant_d && d_wr;
                    addr_d    = grant_d ? {d_addr[ADDR_WIDTH-1:1], 1'b0}
                                        : {i_addr[ADDR_WIDTH-1:1], 1'b0};
                    wdata_d   = grant_d ? d_wdata : 16'h0000;
                    cnt_d     = CNT_INIT;
                    last_d_d  = grant_d;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                busy        = 1'b1;
                mem_enable  = 1'b1;
                mem_addr    = addr_q;
                mem_data_in = wdata_q;
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    // The single write strobe lands on the last held cycle only.
                    mem_wr = wr_q;
                    if (!wr_q) begin
                        if (owner_d_q) d_rdata_d = mem_data_out;
                        else           i_rdata_d = mem_data_out;
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                busy    = 1'b1;
                i_done  = !owner_d_q;
                d_done  = owner_d_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: table of single accesses plus hand-written
// sequences for round-robin, input changes mid-access, reset abort and a LATENCY=1 build.
module tb_mem_port_arbiter;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req, d_req, d_wr;
    logic [15:0] i_addr, d_addr, d_wdata;
    logic        i_done, d_done, mem_enable, mem_wr, busy;
    logic [15:0] i_rdata, d_rdata, mem_addr, mem_data_in, mem_data_out;

    logic        l1_i_req;
    logic [15:0] l1_i_addr;
    logic        l1_i_done, l1_d_done, l1_mem_enable, l1_mem_wr, l1_busy;
    logic [15:0] l1_i_rdata, l1_d_rdata, l1_mem_addr, l1_mem_data_in, l1_mem_data_out;

    int n_chk  = 0;
    int n_fail = 0;
    logic [15:0] i_exp, d_exp;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_WIDTH(16), .LATENCY(LAT)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata),
        .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out), .busy(busy)
    );

    mem_port_arbiter #(.ADDR_WIDTH(16), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .i_req(l1_i_req), .i_addr(l1_i_addr), .i_done(l1_i_done), .i_rdata(l1_i_rdata),
        .d_req(1'b0), .d_wr(1'b0), .d_addr(16'h0000), .d_wdata(16'h0000),
        .d_done(l1_d_done), .d_rdata(l1_d_rdata),
        .mem_enable(l1_mem_enable), .mem_wr(l1_mem_wr), .mem_addr(l1_mem_addr),
        .mem_data_in(l1_mem_data_in), .mem_data_out(l1_mem_data_out), .busy(l1_busy)
    );

    assign l1_mem_data_out = (l1_mem_addr == 16'h0002) ? 16'hC3C3 : 16'h0000;

    // Memory model: fixed preload contents overlaid by words written since clear.
    logic        mem_clr;
    logic [15:0] wmem   [0:255];
    logic        wvalid [0:255];

    function automatic logic [15:0] base_word(input int idx);
        case (idx)
            1:       return 16'h5A5A;
            8:       return 16'hA5A5;
            16:      return 16'h2020;
            24:      return 16'h3030;
            32:      return 16'h4040;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic [15:0] rd_word(input int idx);
        return wvalid[idx] ? wmem[idx] : base_word(idx);
    endfunction

    assign mem_data_out = rd_word(int'(mem_addr[8:1]));

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int k = 0; k < 256; k++) wvalid[k] <= 1'b0;
        end else if (mem_enable && mem_wr) begin
            wmem[int'(mem_addr[8:1])]   <= mem_data_in;
            wvalid[int'(mem_addr[8:1])] <= 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        is_d;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_addr;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t vecs [6];

    task automatic run_vec(input int id, input vec_t v);
        @(negedge clk);
        i_req   = !v.is_d;
        i_addr  = v.is_d ? 16'h0000 : v.addr;
        d_req   = v.is_d;
        d_wr    = v.wr;
        d_addr  = v.is_d ? v.addr : 16'h0000;
        d_wdata = v.wdata;
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            chk("busy_in_access", busy, 1);
            chk("mem_enable", mem_enable, 1);
            chk("mem_addr", mem_addr, v.exp_addr);
            chk("mem_wr", mem_wr, (k == LAT) && v.wr);
            chk("done_during_busy", i_done | d_done, 0);
            if (v.wr) chk("mem_data_in", mem_data_in, v.wdata);
        end
        @(negedge clk);
        if (!v.wr) begin
            if (v.is_d) d_exp = v.exp_rdata;
            else        i_exp = v.exp_rdata;
        end
        chk("i_done", i_done, !v.is_d);
        chk("d_done", d_done, v.is_d);
        chk("i_rdata", i_rdata, i_exp);
        chk("d_rdata", d_rdata, d_exp);
        chk("mem_enable_done", mem_enable, 0);
        chk("busy_done", busy, 1);
        $display("vec %0d: %s %s addr=%h i_rdata=%h d_rdata=%h", id, v.is_d ? "D" : "I",
                 v.wr ? "st" : "ld", v.addr, i_rdata, d_rdata);
        i_req = 1'b0;
        d_req = 1'b0;
        @(negedge clk);
        chk("busy_idle", busy, 0);
        chk("done_idle", i_done | d_done, 0);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
        i_addr = 16'h0000; d_addr = 16'h0000; d_wdata = 16'h0000;
        l1_i_req = 1'b0; l1_i_addr = 16'h0000;
        i_exp = 16'h0000; d_exp = 16'h0000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int t, prev, w;
        logic wr_seen, done_seen;
        logic exp_is_d;

        vecs[0] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'h0010, 16'hA5A5};
        vecs[1] = '{1'b1, 1'b1, 16'h0101, 16'h1234, 16'h0100, 16'h0000};
        vecs[2] = '{1'b1, 1'b0, 16'h0100, 16'h0000, 16'h0100, 16'h1234};
        vecs[3] = '{1'b0, 1'b0, 16'h0003, 16'h0000, 16'h0002, 16'h5A5A};
        vecs[4] = '{1'b1, 1'b1, 16'h0041, 16'h7777, 16'h0040, 16'h0000};
        vecs[5] = '{1'b1, 1'b0, 16'h0040, 16'h0000, 16'h0040, 16'h7777};

        mem_clr = 1'b1;
        apply_reset();
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_mem_enable", mem_enable, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_i_rdata", i_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        chk("rst_done", i_done | d_done, 0);
        @(negedge clk);
        mem_clr = 1'b0;

        for (int n = 0; n < 6; n++) run_vec(n, vecs[n]);

        // Both requesters held: after reset D wins the first tie, then alternate.
        apply_reset();
        @(negedge clk);
        i_req = 1'b1; i_addr = 16'h0010;
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0020;
        t = 0; prev = 0;
        for (int n = 0; n < 4; n++) begin
            exp_is_d = (n % 2 == 0);
            w = 0;
            do begin
                @(negedge clk);
                t++; w++;
            end while (!(i_done || d_done) && w < 20);
            chk("rr_done_seen", i_done | d_done, 1);
            chk("rr_owner_d", d_done, exp_is_d);
            chk("rr_gap", t - prev, (n == 0) ? 5 : 6);
            if (exp_is_d) d_exp = 16'h2020;
            else          i_exp = 16'hA5A5;
            chk("rr_rdata", exp_is_d ? d_rdata : i_rdata, exp_is_d ? d_exp : i_exp);
            $display("rr %0d: i_done=%0b d_done=%0b at cycle %0d", n, i_done, d_done, t);
            prev = t;
        end
        i_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        chk("rr_idle", busy, 0);

        // Address change after grant must not reach the memory.
        @(negedge clk);
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0020;
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            chk("hold_mem_addr", mem_addr, 16'h0020);
            if (k == 2) d_addr = 16'h0040;
        end
        @(negedge clk);
        chk("hold_d_done", d_done, 1);
        chk("hold_d_rdata", d_rdata, 16'h2020);
        $display("addr-hold: d_rdata=%h", d_rdata);
        d_req = 1'b0;
        @(negedge clk);

        // Reset in the 3rd BUSY cycle of a store aborts it completely.
        d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0030; d_wdata = 16'hBEEF;
        wr_seen = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            wr_seen |= mem_wr;
        end
        rst_n = 1'b0;
        d_req = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_mem_enable", mem_enable, 0);
        chk("abort_mem_wr", mem_wr, 0);
        chk("abort_mem_addr", mem_addr, 0);
        chk("abort_d_rdata", d_rdata, 0);
        chk("abort_i_rdata", i_rdata, 0);
        done_seen = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            done_seen |= i_done | d_done;
            wr_seen   |= mem_wr;
            if (k == 1) rst_n = 1'b1;
        end
        chk("abort_wr_seen", wr_seen, 0);
        chk("abort_done_seen", done_seen, 0);
        chk("abort_mem_word", rd_word(24), 16'h3030);
        $display("abort: mem[0x0030]=%h", rd_word(24));
        i_exp = 16'h0000; d_exp = 16'h0000;
        run_vec(6, vecs[0]);

        // LATENCY=1 instance.
        @(negedge clk);
        l1_i_req = 1'b1; l1_i_addr = 16'h0002;
        @(negedge clk);
        chk("l1_busy_1", l1_busy, 1);
        chk("l1_mem_enable", l1_mem_enable, 1);
        chk("l1_mem_addr", l1_mem_addr, 16'h0002);
        chk("l1_mem_wr", l1_mem_wr, 0);
        chk("l1_mem_data_in", l1_mem_data_in, 0);
        chk("l1_i_done_early", l1_i_done, 0);
        @(negedge clk);
        chk("l1_busy_2", l1_busy, 1);
        chk("l1_i_done", l1_i_done, 1);
        chk("l1_d_done", l1_d_done, 0);
        chk("l1_i_rdata", l1_i_rdata, 16'hC3C3);
        chk("l1_d_rdata", l1_d_rdata, 0);
        $display("l1: i_rdata=%h", l1_i_rdata);
        l1_i_req = 1'b0;
        @(negedge clk);
        chk("l1_busy_3", l1_busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
